matmul_result_checker: RTL

- Synthesizable APB master that sits directly downstream of the matmul IP, in parallel with the stimulus APB master; a bench mux grants the bus to one master at a time.
- After the stimulus has loaded A/B and started the IP, the checker polls the IP STATUS register until DONE is set.
- It then reads all N*N result words of C over APB and compares each against a golden-model expected-value ROM.
- It reports pass/fail, mismatch count, first failing index and a timeout flag.

---
 rtl/matmul_pkg.sv | 19 +
 rtl/matmul_apb_rd_master.sv | 45 ++++
 rtl/matmul_result_checker.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared register map and checker state encoding for the matmul IP and its result checker.
package matmul_pkg;

    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] C_BASE_OFS = 32'h0000_0200;
    localparam int          DONE_BIT   = 0;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        POLL_SETUP  = 3'd1,
        POLL_ACCESS = 3'd2,
        POLL_WAIT   = 3'd3,
        RD_SETUP    = 3'd4,
        RD_ACCESS   = 3'd5,
        CMP         = 3'd6,
        FIN         = 3'd7
    } chk_state_e;

endpackage

// File: rtl/matmul_apb_rd_master.sv
// Single-read APB master: a one-cycle req_i is the SETUP phase, ACCESS is held until pready_i.
module matmul_apb_rd_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              slverr_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    logic              access_q;
    logic [ADDR_W-1:0] addr_q;

    // Abort drops the bus on the next edge without producing an ack.
    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            access_q <= 1'b0;
            addr_q   <= '0;
        end else if (req_i) begin
            access_q <= 1'b1;
            addr_q   <= addr_i;
        end else if (access_q && pready_i) begin
            access_q <= 1'b0;
        end
    end

    assign psel_o    = req_i | access_q;
    assign penable_o = access_q;
    assign paddr_o   = access_q ? addr_q : addr_i;
    assign ack_o     = access_q & pready_i;
    assign rdata_o   = prdata_i;
    assign slverr_o  = pslverr_i;

endmodule

// File: rtl/matmul_result_checker.sv
// Polls the matmul IP for DONE, then reads every C element over APB and compares it to the expected ROM.
module matmul_result_checker
    import matmul_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                N           = 4,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(STATUS_OFS),
    parameter logic [ADDR_W-1:0] C_BASE_ADDR = ADDR_W'(C_BASE_OFS),
    parameter int                POLL_GAP    = 8,
    parameter int                TIMEOUT     = 4096,
    localparam int               IDX_W       = $clog2(N*N),
    localparam int               CNT_W       = $clog2(N*N) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i,
    output logic [IDX_W-1:0]  exp_addr_o,
    input  logic [DATA_W-1:0] exp_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  mismatch_cnt_o,
    output logic [IDX_W-1:0]  first_err_idx_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);

    chk_state_e        state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  k_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [GAP_W-1:0]  gap_q;
    logic              first_q;
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] rd_q;
    logic              err_q;

    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  first_err_q;
    logic [IDX_W-1:0]  exp_addr_q;

    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              slverr;
    logic              in_poll;
    logic              tmo_hit;
    logic              elem_fail;
    logic              last_elem;
    logic              status_done;
    logic [IDX_W-1:0]  k_d;

    assign in_poll     = (state_q == POLL_SETUP) || (state_q == POLL_ACCESS) ||
                         (state_q == POLL_WAIT);
    assign tmo_hit     = in_poll && (tmr_q == TMR_W'(TIMEOUT - 1));
    assign elem_fail   = err_q || (rd_q != exp_q);
    assign last_elem   = (k_q == IDX_W'(N*N - 1));
    assign status_done = rdata[DONE_BIT] && !slverr;
    assign k_d         = k_q + IDX_W'(1);

    matmul_apb_rd_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_master (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_q),
        .abort_i   (tmo_hit),
        .addr_i    (addr_q),
        .ack_o     (ack),
        .rdata_o   (rdata),
        .slverr_o  (slverr),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .paddr_o   (paddr_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            k_q         <= '0;
            tmr_q       <= '0;
            gap_q       <= '0;
            first_q     <= 1'b0;
            exp_q       <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            first_err_q <= '0;
            exp_addr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            req_q  <= 1'b0;
            if (in_poll) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end
            if (tmo_hit) begin
                timeout_q <= 1'b1;
                pass_q    <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                state_q   <= FIN;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            pass_q      <= 1'b0;
                            timeout_q   <= 1'b0;
                            cnt_q       <= '0;
                            first_err_q <= '0;
                            k_q         <= '0;
                            exp_addr_q  <= '0;
                            tmr_q       <= '0;
                            busy_q      <= 1'b1;
                            req_q       <= 1'b1;
                            addr_q      <= STATUS_ADDR;
                            state_q     <= POLL_SETUP;
                        end
                    end
                    POLL_SETUP: state_q <= POLL_ACCESS;
                    POLL_ACCESS: begin
                        if (ack) begin
                            if (status_done) begin
                                req_q      <= 1'b1;
                                addr_q     <= C_BASE_ADDR;
                                exp_addr_q <= '0;
                                state_q    <= RD_SETUP;
                            end else begin
                                gap_q   <= '0;
                                state_q <= POLL_WAIT;
                            end
                        end
                    end
                    POLL_WAIT: begin
                        if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                            req_q   <= 1'b1;
                            state_q <= POLL_SETUP;
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                    RD_SETUP: begin
                        first_q <= 1'b1;
                        state_q <= RD_ACCESS;
                    end
                    RD_ACCESS: begin
                        // The ROM output is valid from the first ACCESS cycle onward.
                        first_q <= 1'b0;
                        if (first_q) begin
                            exp_q <= exp_data_i;
                        end
                        if (ack) begin
                            rd_q    <= rdata;
                            err_q   <= slverr;
                            state_q <= CMP;
                        end
                    end
                    CMP: begin
                        if (elem_fail) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == '0) begin
                                first_err_q <= k_q;
                            end
                        end
                        if (last_elem) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            pass_q  <= (cnt_q == '0) && !elem_fail;
                            state_q <= FIN;
                        end else begin
                            k_q        <= k_d;
                            exp_addr_q <= k_d;
                            addr_q     <= C_BASE_ADDR + (ADDR_W'(k_d) << 2);
                            req_q      <= 1'b1;
                            state_q    <= RD_SETUP;
                        end
                    end
                    FIN:     state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pwrite_o        = 1'b0;
    assign exp_addr_o      = exp_addr_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign timeout_o       = timeout_q;
    assign mismatch_cnt_o  = cnt_q;
    assign first_err_idx_o = first_err_q;

endmodule
